pipe_input_arbiter: RTL and testbench

- Round-robin arbiter that shares one pipeline stage input among NUM_REQ upstream producers.
- Speaks the DOR/DIR/ack handshake on both sides:
  - Toward each producer it acts as the consuming stage.
  - Toward the downstream stage it acts as a single producer.
- Each granted word is buffered, then presented downstream with a source tag until the downstream stage acknowledges it.

---
 rtl/pipe_input_arbiter_pkg.sv | 25 ++
 rtl/pipe_input_arbiter_rr_pick.sv | 42 ++++
 rtl/pipe_input_arbiter.sv | 143 ++++++++++++++
 tb/tb_pipe_input_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_input_arbiter_pkg.sv
// Shared definitions for the pipeline input arbiter: handshake state encoding,
// handshake polarities and width helpers.
package pipe_input_arbiter_pkg;

   // Same 1-bit encoding the pipeline stages use for their handshake FSMs.
   typedef enum logic {
      IDLE        = 1'b0,
      WAITING_ACK = 1'b1
   } state_t;

   // Active level of DOR/DIR lines and of acknowledge lines.
   localparam logic DOR_ACTIVE = 1'b1;
   localparam logic ACK_ACTIVE = 1'b1;

   // Width of a requester index (at least one bit).
   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must be able to hold the value 'limit'.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/pipe_input_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Scans last_grant+1, last_grant+2, ... (modulo NUM_REQ) and returns the first
// asserted request.
//   req        : active-high request vector
//   last_grant : index granted most recently
//   any_req_c  : at least one request is asserted
//   grant_c    : selected index (0 when no request)
module pipe_input_arbiter_rr_pick
   import pipe_input_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic               any_req_c,
   output logic [ID_W-1:0]    grant_c
);

   int unsigned idx;
   logic        found;

   assign any_req_c = |req;

   // last_grant < NUM_REQ, so one conditional subtract implements the wrap.
   always_comb begin
      grant_c = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[ID_W'(idx)]) begin
            found   = 1'b1;
            grant_c = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/pipe_input_arbiter.sv
// Round-robin arbiter sharing one pipeline stage input among NUM_REQ producers.
// A granted word is registered and presented downstream with its source index
// until the downstream stage acknowledges it.
//   clk, reset     : clock, synchronous active-low reset
//   req_dor        : per-requester data-output-ready
//   req_data       : flattened request words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack        : per-requester one-cycle acknowledge
//   DOR            : data ready toward the downstream stage
//   data_out       : buffered word of the granted requester
//   src_id         : index of the granted requester
//   ack_from_next  : acknowledge from the downstream stage
//   busy           : high while waiting for the downstream ack
//   timeout_err    : sticky flag, set after TIMEOUT unacknowledged wait cycles
//   clear_err      : clears timeout_err (a simultaneous new timeout wins)
module pipe_input_arbiter
   import pipe_input_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned TIMEOUT    = 255,
   localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_dor,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic                          DOR,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic [ID_W-1:0]               src_id,
   input  logic                          ack_from_next,
   output logic                          busy,
   output logic                          timeout_err,
   input  logic                          clear_err
);

   localparam int unsigned      CNT_W   = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t                  state, state_n;
   logic [NUM_REQ-1:0]      req_ack_n;
   logic                    dor_n;
   logic [DATA_WIDTH-1:0]   data_n;
   logic [ID_W-1:0]         src_n;
   logic                    busy_n;
   logic                    err_n;
   logic [CNT_W-1:0]        wait_cnt, wait_cnt_n;
   logic [ID_W-1:0]         last_grant, last_grant_n;
   logic                    tmo_hit;

   logic [NUM_REQ-1:0]      req_act;
   logic                    ack_act;
   logic                    any_req_c;
   logic [ID_W-1:0]         grant_c;
   logic [DATA_WIDTH-1:0]   req_words [NUM_REQ];

   assign req_act = req_dor ^ {NUM_REQ{~DOR_ACTIVE}};
   assign ack_act = (ack_from_next == ACK_ACTIVE);

   // Unpack the flattened request bus into per-requester words.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   pipe_input_arbiter_rr_pick #(
      .NUM_REQ    (NUM_REQ)
   ) u_rr_pick (
      .req        (req_act),
      .last_grant (last_grant),
      .any_req_c  (any_req_c),
      .grant_c    (grant_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state;
      req_ack_n    = {NUM_REQ{~ACK_ACTIVE}};
      dor_n        = DOR;
      data_n       = data_out;
      src_n        = src_id;
      busy_n       = busy;
      wait_cnt_n   = wait_cnt;
      last_grant_n = last_grant;
      tmo_hit      = 1'b0;

      case (state)
         IDLE: begin
            if (any_req_c) begin
               data_n             = req_words[grant_c];
               src_n              = grant_c;
               req_ack_n[grant_c] = ACK_ACTIVE;
               dor_n              = DOR_ACTIVE;
               busy_n             = 1'b1;
               last_grant_n       = grant_c;
               wait_cnt_n         = '0;
               state_n            = WAITING_ACK;
            end
         end
         WAITING_ACK: begin
            if (ack_act) begin
               dor_n   = ~DOR_ACTIVE;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else if (wait_cnt != CNT_MAX) begin
               // Timeout fires only on the transition into CNT_MAX.
               wait_cnt_n = wait_cnt + CNT_W'(1);
               tmo_hit    = (wait_cnt_n == CNT_MAX);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      err_n = tmo_hit | (timeout_err & ~clear_err);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         req_ack     <= {NUM_REQ{~ACK_ACTIVE}};
         DOR         <= ~DOR_ACTIVE;
         data_out    <= '0;
         src_id      <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
         last_grant  <= ID_W'(NUM_REQ - 1);
      end else begin
         state       <= state_n;
         req_ack     <= req_ack_n;
         DOR         <= dor_n;
         data_out    <= data_n;
         src_id      <= src_n;
         busy        <= busy_n;
         timeout_err <= err_n;
         wait_cnt    <= wait_cnt_n;
         last_grant  <= last_grant_n;
      end
   end

endmodule

// File: tb/tb_pipe_input_arbiter.sv
// Self-checking bench for pipe_input_arbiter: directed scenarios with literal
// expectations plus randomized producers/downstream checked every cycle
// against a behavioural model.
module tb_pipe_input_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int TMO = 8;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_dor;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ack;
   logic             DOR;
   logic [DW-1:0]    data_out;
   logic [IDW-1:0]   src_id;
   logic             ack_from_next;
   logic             busy;
   logic             timeout_err;
   logic             clear_err;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   bit            m_wait = 1'b0;
   int            m_last = NR - 1;
   int            m_id   = 0;
   int            m_cnt  = 0;
   logic [DW-1:0] m_dout = '0;
   logic [NR-1:0] m_ack  = '0;
   bit            m_err  = 1'b0;

   bit late [NR];

   always #5 clk = ~clk;

   pipe_input_arbiter #(
      .NUM_REQ       (NR),
      .DATA_WIDTH    (DW),
      .TIMEOUT       (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_dor       (req_dor),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .DOR           (DOR),
      .data_out      (data_out),
      .src_id        (src_id),
      .ack_from_next (ack_from_next),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .clear_err     (clear_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One rising edge of the reference behaviour.
   task automatic model_step();
      bit tmo;
      bit hit;
      int j;
      if (!reset) begin
         m_wait = 1'b0; m_dout = '0; m_id = 0; m_last = NR - 1;
         m_cnt = 0; m_err = 1'b0; m_ack = '0;
         return;
      end
      tmo = 1'b0;
      hit = 1'b0;
      m_ack = '0;
      if (!m_wait) begin
         for (int k = 1; k <= NR; k++) begin
            j = (m_last + k) % NR;
            if (!hit && req_dor[j]) begin
               hit = 1'b1;
               m_wait = 1'b1;
               m_last = j;
               m_id = j;
               m_dout = req_data[j*DW +: DW];
               m_ack[j] = 1'b1;
               m_cnt = 0;
            end
         end
      end else if (ack_from_next) begin
         m_wait = 1'b0;
      end else if (m_cnt < TMO) begin
         m_cnt++;
         if (m_cnt == TMO) tmo = 1'b1;
      end
      m_err = tmo | (m_err & ~clear_err);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("req_ack",     32'(req_ack),     32'(m_ack));
         chk("DOR",         32'(DOR),         32'(m_wait));
         chk("busy",        32'(busy),        32'(m_wait));
         chk("data_out",    32'(data_out),    32'(m_dout));
         chk("src_id",      32'(src_id),      32'(m_id));
         chk("timeout_err", 32'(timeout_err), 32'(m_err));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_word(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   logic [IDW-1:0] exp_id   [5];
   logic [DW-1:0]  exp_data [5];

   initial begin
      reset = 1'b0; req_dor = '0; req_data = '0; ack_from_next = 1'b0; clear_err = 1'b0;
      exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_data = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd10};

      // Reset state
      tick();
      chk_en = 1'b1;
      chk("rst_dor",  32'(DOR),         32'd0);
      chk("rst_data", 32'(data_out),    32'd0);
      chk("rst_src",  32'(src_id),      32'd0);
      chk("rst_busy", 32'(busy),        32'd0);
      chk("rst_err",  32'(timeout_err), 32'd0);
      chk("rst_ack",  32'(req_ack),     32'd0);

      // Single request from requester 2
      reset = 1'b1; req_dor = 4'b0100; set_word(2, 8'd33);
      tick();
      chk("t1_ack",  32'(req_ack),  32'h4);
      chk("t1_dor",  32'(DOR),      32'd1);
      chk("t1_data", 32'(data_out), 32'd33);
      chk("t1_src",  32'(src_id),   32'd2);
      req_dor = '0;
      tick();
      chk("t1_ack_pulse", 32'(req_ack), 32'd0);
      tick();
      ack_from_next = 1'b1;
      tick();
      ack_from_next = 1'b0;
      chk("t1_dor_done",  32'(DOR),  32'd0);
      chk("t1_busy_done", 32'(busy), 32'd0);

      // Round robin with all requesters held high
      reset = 1'b0;
      tick();
      reset = 1'b1; req_dor = 4'hF;
      for (int i = 0; i < NR; i++) set_word(i, 8'(10 + i));
      tick();
      for (int g = 0; g < 5; g++) begin
         chk("rr_src",  32'(src_id),   32'(exp_id[g]));
         chk("rr_data", 32'(data_out), 32'(exp_data[g]));
         chk("rr_ack",  32'(req_ack),  32'(4'b0001 << exp_id[g]));
         tick();
         chk("rr_ack_width", 32'(req_ack), 32'd0);
         ack_from_next = 1'b1;
         tick();
         ack_from_next = 1'b0;
         chk("rr_dor_gap", 32'(DOR), 32'd0);
         if (g == 4) req_dor = '0;
         tick();
      end

      // Hold under backpressure
      req_dor = 4'b0010; set_word(1, 8'hA5);
      tick();
      chk("hold_src0",  32'(src_id),   32'd1);
      chk("hold_data0", 32'(data_out), 32'hA5);
      req_dor = 4'b1101;
      for (int c = 0; c < 20; c++) begin
         req_data = 32'($urandom);
         tick();
         chk("hold_data", 32'(data_out), 32'hA5);
         chk("hold_src",  32'(src_id),   32'd1);
         chk("hold_ack",  32'(req_ack),  32'd0);
      end
      ack_from_next = 1'b1; req_dor = '0;
      tick();
      ack_from_next = 1'b0;
      chk("hold_release", 32'(DOR), 32'd0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;

      // Timeout after TMO unacknowledged wait cycles
      req_dor = 4'b1000; set_word(3, 8'h5C);
      tick();
      chk("tmo_src", 32'(src_id), 32'd3);
      req_dor = '0;
      repeat (TMO - 1) tick();
      chk("tmo_not_yet", 32'(timeout_err), 32'd0);
      tick();
      chk("tmo_set",     32'(timeout_err), 32'd1);
      chk("tmo_dor",     32'(DOR),         32'd1);
      ack_from_next = 1'b1;
      tick();
      ack_from_next = 1'b0;
      chk("tmo_late_dor", 32'(DOR),         32'd0);
      chk("tmo_sticky",   32'(timeout_err), 32'd1);
      // clear_err coinciding with a new timeout: set wins
      req_dor = 4'b0001;
      tick();
      chk("tmo2_src", 32'(src_id), 32'd0);
      req_dor = '0;
      repeat (TMO - 1) tick();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("tmo_set_wins", 32'(timeout_err), 32'd1);
      ack_from_next = 1'b1;
      tick();
      ack_from_next = 1'b0;
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("tmo_cleared", 32'(timeout_err), 32'd0);

      // Ack on the cycle the counter would reach TMO
      req_dor = 4'b0010;
      tick();
      req_dor = '0;
      repeat (TMO - 1) tick();
      ack_from_next = 1'b1;
      tick();
      ack_from_next = 1'b0;
      chk("coll_err", 32'(timeout_err), 32'd0);
      chk("coll_dor", 32'(DOR),         32'd0);

      // Reset while waiting on requester 3
      req_dor = 4'b1000;
      tick();
      chk("rstmid_src", 32'(src_id), 32'd3);
      req_dor = '0;
      tick();
      tick();
      reset = 1'b0; req_dor = 4'hF;
      for (int i = 0; i < NR; i++) set_word(i, 8'(10 + i));
      tick();
      chk("rstmid_dor",  32'(DOR),      32'd0);
      chk("rstmid_busy", 32'(busy),     32'd0);
      chk("rstmid_data", 32'(data_out), 32'd0);
      chk("rstmid_ack",  32'(req_ack),  32'd0);
      reset = 1'b1;
      tick();
      chk("rstmid_first_src", 32'(src_id),  32'd0);
      chk("rstmid_first_ack", 32'(req_ack), 32'd1);
      req_dor = '0; ack_from_next = 1'b1;
      tick();
      ack_from_next = 1'b0;

      // Randomized producers and downstream
      for (int i = 0; i < NR; i++) late[i] = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         tick();
         for (int i = 0; i < NR; i++) begin
            if (m_ack[i]) begin
               if ($urandom_range(0, 1) == 1) req_dor[i] = 1'b0;
               else late[i] = 1'b1;
            end else if (late[i]) begin
               req_dor[i] = 1'b0;
               late[i] = 1'b0;
            end else if (!req_dor[i] && $urandom_range(0, 3) == 0) begin
               req_dor[i] = 1'b1;
               set_word(i, DW'($urandom));
            end
         end
         ack_from_next = ($urandom_range(0, 99) < ((c < 2000) ? 40 : 4));
         clear_err     = ($urandom_range(0, 39) == 0);
         reset         = ($urandom_range(0, 599) != 0);
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
